uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Asynchronous serial receiver: 8N1 frames, LSB first, on the core clock domain. It is the receive half of the UART link whose transmit half the core already drives. It feeds the memory-mapped rx_data / rx_ready registers and is cleared through the memory-mapped clean_rx register. It provides a sticky ready flag, plus framing-error and overrun detection, so polled firmware can recover.

Parameters:
CLK_FREQ, 50000000, core clock frequency in Hz.
BAUD_RATE, 115200, line bit rate.
DATA_BITS, 8, payload bits per frame.
CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (integer division; 434 at defaults), clocks per bit period. Must be at least 4.

Ports:
clk  in  1  core clock (not the divided CPU clock).
reset  in  1  asynchronous, active-low reset.
rx_pin  in  1  serial line, asynchronous, idle high.
clear_rx  in  1  one-cycle pulse; clears rx_ready and overrun.
rx_data  out  DATA_BITS  last correctly framed byte.
rx_ready  out  1  sticky; a new byte is available.
framing_error  out  1  last frame had stop bit = 0.
overrun  out  1  a byte completed while rx_ready was already 1.
rx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, all counters 0, synchronizer flops=1.
  - rx_data=0; rx_ready=0; framing_error=0; overrun=0; rx_busy=0.
- Input synchronization:
  - rx_pin passes through a 2-flop synchronizer to give rx_s.
  - All decisions use rx_s, so there is 2 cycles of input latency.
- State machine states: IDLE, START, DATA, STOP, BREAK.
- Counters:
  - clk_cnt counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - bit_idx counts 0..DATA_BITS-1.
- IDLE:
  - rx_s=0 → go to START, clk_cnt=0.
- START:
  - When clk_cnt reaches CLKS_PER_BIT/2-1, sample rx_s.
  - Sample 0 → go to DATA, clk_cnt=0, bit_idx=0.
  - Sample 1 → treat as a glitch and return to IDLE. No flags change.
- DATA:
  - When clk_cnt reaches CLKS_PER_BIT-1: shift rx_s into the shift register MSB, shifting right (LSB arrives first), then clk_cnt=0 and bit_idx+1.
  - After the DATA_BITS-th sample → go to STOP.
- STOP:
  - When clk_cnt reaches CLKS_PER_BIT-1, sample rx_s.
  - Sample 1: rx_data<=shift register, rx_ready<=1, framing_error<=0; if rx_ready was already 1 and clear_rx=0, overrun<=1. Go to IDLE.
  - Sample 0: framing_error<=1; rx_data, rx_ready and overrun are unchanged. Go to BREAK.
- BREAK:
  - Wait until rx_s=1, then go to IDLE. A held-low line therefore never produces bytes.
- clear_rx:
  - A pulse sets rx_ready<=0 and overrun<=0 in the next cycle.
  - framing_error is cleared only by the next good frame.
- Simultaneous clear_rx and good-frame completion in the same cycle: completion wins, rx_ready=1, overrun is not set.
- Latency: rx_ready rises 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT (±1) clocks after the start-bit falling edge on rx_pin.
- Back-to-back frames:
  - A frame is accepted immediately after STOP because IDLE re-arms in the next cycle.
  - The mid-stop sample leaves half a bit of margin.
- Reset mid-frame: the partial frame is discarded and all outputs return to their reset values.

Decomposition:
- Shared package uart_pkg holds:
  - the rx state enum;
  - the CLKS_PER_BIT derivation function;
  - the DATA_BITS default.
- The transmitter reuses the same package.
- One sub-module, sync_2ff: generic 2-flop synchronizer with a reset-value parameter (1 here), reusable for other asynchronous inputs.

Test Plan (CLK_FREQ=1000000, BAUD_RATE=100000, so CLKS_PER_BIT=10):
- Ideal frame for 0xA5, then idle → rx_ready rises about 97 clocks after the start edge; rx_data=0xA5; framing_error=0; overrun=0.
- Frames 0x3C then 0xC3, with no clear_rx between them → rx_data=0xC3; rx_ready=1; overrun=1. Then pulse clear_rx → rx_ready=0 and overrun=0 one cycle later.
- 3-clock low glitch on an idle line → START rejects it; state returns to IDLE; rx_ready and rx_busy end at 0; no data change.
- Frame 0x55 with stop bit forced 0, held low for 30 clocks, then a good 0x12 frame → framing_error=1 with rx_data unchanged; stays in BREAK while low. After the good frame: rx_data=0x12, framing_error=0.
- clear_rx asserted in the exact cycle a second frame completes → rx_ready=1; overrun=0; rx_data equals the second byte.
- reset=0 asserted during bit 4 of a frame, released 5 clocks later, then a good 0x81 frame → all outputs 0 during reset; 0x81 is received correctly with no spurious byte.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types and helpers for the receive and transmit halves.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DEFAULT_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Generic two-flop synchronizer for asynchronous inputs.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 asynchronous serial receiver with sticky ready, framing-error
//            and overrun flags for polled firmware.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 115200,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_pin,
    input  logic                 clear_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam int c_idx_w = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_cnt_w-1:0] c_half_cnt = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DATA_BITS - 1);

    logic w_rx_s;

    rx_state_t              r_state;
    rx_state_t              w_state_next;
    logic [c_cnt_w-1:0]     r_clk_cnt;
    logic [c_cnt_w-1:0]     w_clk_cnt_next;
    logic [c_idx_w-1:0]     r_bit_idx;
    logic [c_idx_w-1:0]     w_bit_idx_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic [DATA_BITS-1:0]   w_rx_data_next;
    logic                   r_rx_ready;
    logic                   w_rx_ready_next;
    logic                   r_framing_error;
    logic                   w_framing_error_next;
    logic                   r_overrun;
    logic                   w_overrun_next;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_sync_rx (
        .clk   (clk),
        .reset (reset),
        .d     (rx_pin),
        .q     (w_rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_clk_cnt       <= '0;
            r_bit_idx       <= '0;
            r_shift         <= '0;
            r_rx_data       <= '0;
            r_rx_ready      <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_clk_cnt       <= w_clk_cnt_next;
            r_bit_idx       <= w_bit_idx_next;
            r_shift         <= w_shift_next;
            r_rx_data       <= w_rx_data_next;
            r_rx_ready      <= w_rx_ready_next;
            r_framing_error <= w_framing_error_next;
            r_overrun       <= w_overrun_next;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        w_clk_cnt_next       = r_clk_cnt + 1'b1;
        w_bit_idx_next       = r_bit_idx;
        w_shift_next         = r_shift;
        w_rx_data_next       = r_rx_data;
        w_rx_ready_next      = clear_rx ? 1'b0 : r_rx_ready;
        w_framing_error_next = r_framing_error;
        w_overrun_next       = clear_rx ? 1'b0 : r_overrun;

        case (r_state)
            ST_IDLE: begin
                w_clk_cnt_next = '0;
                if (!w_rx_s) begin
                    w_state_next = ST_START;
                end
            end

            ST_START: begin
                // A start bit that is high again at mid-bit is a line glitch.
                if (r_clk_cnt == c_half_cnt) begin
                    w_clk_cnt_next = '0;
                    if (!w_rx_s) begin
                        w_state_next   = ST_DATA;
                        w_bit_idx_next = '0;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                if (r_clk_cnt == c_full_cnt) begin
                    w_clk_cnt_next = '0;
                    w_shift_next   = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    if (r_bit_idx == c_last_idx) begin
                        w_bit_idx_next = '0;
                        w_state_next   = ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end

            ST_STOP: begin
                if (r_clk_cnt == c_full_cnt) begin
                    w_clk_cnt_next = '0;
                    if (w_rx_s) begin
                        // Completion beats a coincident clear; overrun only if the old byte was unread.
                        w_rx_data_next       = r_shift;
                        w_rx_ready_next      = 1'b1;
                        w_framing_error_next = 1'b0;
                        if (r_rx_ready && !clear_rx) begin
                            w_overrun_next = 1'b1;
                        end
                        w_state_next = ST_IDLE;
                    end else begin
                        w_framing_error_next = 1'b1;
                        w_state_next         = ST_BREAK;
                    end
                end
            end

            ST_BREAK: begin
                w_clk_cnt_next = '0;
                if (w_rx_s) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next   = ST_IDLE;
                w_clk_cnt_next = '0;
                w_bit_idx_next = '0;
            end
        endcase
    end

    assign rx_data       = r_rx_data;
    assign rx_ready      = r_rx_ready;
    assign framing_error = r_framing_error;
    assign overrun       = r_overrun;
    assign rx_busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx with a byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_clk_freq = 1000000;
    localparam int c_baud     = 100000;
    localparam int c_cpb      = c_clk_freq / c_baud;

    logic       clk;
    logic       reset;
    logic       rx_pin;
    logic       clear_rx;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       framing_error;
    logic       overrun;
    logic       rx_busy;

    int         n_checks;
    int         n_errors;
    int         cyc;
    int         start_cycle;
    int         done_cycle;
    logic [7:0] exp_q[$];
    logic       prev_ready;
    logic [7:0] prev_data;

    uart_rx #(
        .CLK_FREQ  (c_clk_freq),
        .BAUD_RATE (c_baud),
        .DATA_BITS (8)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .rx_pin        (rx_pin),
        .clear_rx      (clear_rx),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .framing_error (framing_error),
        .overrun       (overrun),
        .rx_busy       (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // A new byte shows up as a rising ready or a change of the data register.
    always @(negedge clk) begin
        if (!reset) begin
            prev_ready <= 1'b0;
            prev_data  <= 8'h00;
        end else begin
            prev_ready <= rx_ready;
            prev_data  <= rx_data;
            if ((rx_ready && !prev_ready) || (rx_data != prev_data)) begin
                done_cycle <= cyc;
                if (exp_q.size() == 0)
                    check("sb_spurious_byte", 32'(rx_data), 32'h0000_0dea);
                else
                    check("sb_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // clr_at >= 0 pulses clear_rx on that clock of the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit push, input int clr_at);
        if (push) exp_q.push_back(b);
        @(negedge clk);
        rx_pin      = 1'b0;
        start_cycle = cyc;
        repeat (c_cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (c_cpb) @(negedge clk);
        end
        rx_pin = stop;
        for (int j = 0; j < c_cpb; j++) begin
            clear_rx = (j == clr_at);
            @(negedge clk);
        end
        clear_rx = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_rx = 1'b1;
        @(negedge clk);
        clear_rx = 1'b0;
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        done_cycle = 0;
        reset      = 1'b0;
        rx_pin     = 1'b1;
        clear_rx   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",  32'(rx_data), 0);
        check("rst_ready", 32'(rx_ready), 0);
        check("rst_ferr",  32'(framing_error), 0);
        check("rst_ovr",   32'(overrun), 0);
        check("rst_busy",  32'(rx_busy), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Ideal frame and latency
        send_frame(8'hA5, 1'b1, 1'b1, -1);
        lat = done_cycle - start_cycle;
        check("a5_latency_in_window", 32'((lat >= 96) && (lat <= 98)), 1);
        check("a5_data",  32'(rx_data), 32'hA5);
        check("a5_ready", 32'(rx_ready), 1);
        check("a5_ferr",  32'(framing_error), 0);
        check("a5_ovr",   32'(overrun), 0);
        pulse_clear();
        check("a5_cleared", 32'(rx_ready), 0);

        // Overrun on two unread frames, then clear
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        send_frame(8'hC3, 1'b1, 1'b1, -1);
        check("ovr_data",  32'(rx_data), 32'hC3);
        check("ovr_ready", 32'(rx_ready), 1);
        check("ovr_flag",  32'(overrun), 1);
        pulse_clear();
        check("ovr_clr_ready", 32'(rx_ready), 0);
        check("ovr_clr_flag",  32'(overrun), 0);

        // Short low glitch on idle line
        @(negedge clk);
        rx_pin = 1'b0;
        repeat (3) @(negedge clk);
        rx_pin = 1'b1;
        @(negedge clk);
        check("glitch_in_start", 32'(rx_busy), 1);
        repeat (20) @(negedge clk);
        check("glitch_busy",  32'(rx_busy), 0);
        check("glitch_ready", 32'(rx_ready), 0);
        check("glitch_data",  32'(rx_data), 32'hC3);

        // Framing error, held break, then recovery
        send_frame(8'h55, 1'b0, 1'b0, -1);
        repeat (30) @(negedge clk);
        check("brk_ferr",  32'(framing_error), 1);
        check("brk_data",  32'(rx_data), 32'hC3);
        check("brk_ready", 32'(rx_ready), 0);
        check("brk_busy",  32'(rx_busy), 1);
        rx_pin = 1'b1;
        repeat (5) @(negedge clk);
        check("brk_exit_busy", 32'(rx_busy), 0);
        send_frame(8'h12, 1'b1, 1'b1, -1);
        check("rec_data", 32'(rx_data), 32'h12);
        check("rec_ferr", 32'(framing_error), 0);

        // clear_rx coincident with completion (stop sample lands on clock 7 of the stop bit)
        send_frame(8'h6E, 1'b1, 1'b1, 7);
        repeat (2) @(negedge clk);
        check("coinc_ready", 32'(rx_ready), 1);
        check("coinc_ovr",   32'(overrun), 0);
        check("coinc_data",  32'(rx_data), 32'h6E);

        // Reset during bit 4 of a frame
        @(negedge clk);
        rx_pin = 1'b0;
        repeat (c_cpb) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_pin = i[0];
            repeat (c_cpb) @(negedge clk);
        end
        rx_pin = 1'b1;
        repeat (4) @(negedge clk);
        reset  = 1'b0;
        @(negedge clk);
        check("mid_rst_data",  32'(rx_data), 0);
        check("mid_rst_ready", 32'(rx_ready), 0);
        check("mid_rst_ferr",  32'(framing_error), 0);
        check("mid_rst_ovr",   32'(overrun), 0);
        check("mid_rst_busy",  32'(rx_busy), 0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h81, 1'b1, 1'b1, -1);
        repeat (2) @(negedge clk);
        check("post_rst_data",  32'(rx_data), 32'h81);
        check("post_rst_ready", 32'(rx_ready), 1);
        check("post_rst_ovr",   32'(overrun), 0);
        check("post_rst_ferr",  32'(framing_error), 0);

        repeat (20) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
